ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
- Host-side PS/2 receiver. Samples the device-driven ps2_clk/ps2_dat pair and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Valid bytes are pushed into a small FIFO, which a bus-side reader drains through a valid/ready handshake.
- Sits between the PS/2 keyboard pins and the SoC's keyboard register block.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the receive FIFO. Power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, system-clock cycles allowed between consecutive ps2_clk falling edges inside a frame before the frame is aborted (2 ms at 25 MHz). Counter width 16 bits.

Ports:
- clock  in  1  system clock (25 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from the device, asynchronous to clock.
- ps2_dat  in  1  PS/2 data from the device, asynchronous to clock.
- rd_ready  in  1  reader accepts the head byte this cycle.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_data  out  8  head-of-FIFO byte; 0x00 when empty.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, bit counter 0, timeout counter 0.
- Reset asserted mid-frame discards the partial frame and all FIFO contents.
- Synchronisation: ps2_clk and ps2_dat each pass through a 2-FF synchroniser. Synchronised registers reset to 1 (bus idle).
- Edge detect: a registered copy of synchronised clk provides the previous value. fall = prev & ~cur. Data is sampled from synchronised dat in the same cycle fall is high.
- State machine:
  - IDLE: on fall with dat=0, go to RECV with bitcnt=1. On fall with dat=1, ignore (stay IDLE).
  - RECV: on each fall, shift dat into shreg[bitcnt-1] and increment bitcnt.
    - bitcnt 1..8 capture data bits d0..d7.
    - bitcnt 9 captures parity.
    - bitcnt 10 captures stop, then go to CHECK.
  - CHECK (one cycle): frame is good when (^data ^ parity)==1 and stop==1.
    - Good: push data, return to IDLE.
    - Bad: pulse frame_err, discard, return to IDLE.
- Timeout: in RECV the counter increments every cycle and clears on each fall. When it reaches TIMEOUT_CYCLES-1, pulse frame_err, clear bitcnt, go to IDLE. The timeout counter is held at 0 in IDLE.
- Latency: byte visible on rd_valid/rd_data exactly 2 cycles after the cycle in which fall is high for the stop bit (CHECK cycle, then FIFO write).
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count register of width log2(FIFO_DEPTH)+1.
  - Pop occurs when rd_valid & rd_ready.
  - rd_data is combinationally the head entry; forced to 0x00 when empty.
- Full boundary:
  - Push while full with no pop: byte dropped, overflow set to 1, contents unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, overflow not set.
- Empty boundary:
  - rd_ready while empty has no effect.
  - Push while empty: rd_valid rises the next cycle.
- overflow stays high until a cycle with clr_overflow=1. If clr_overflow and a new drop coincide, set wins.
- frame_err never asserts for a frame that was pushed or dropped as overflow. It is only a one-cycle pulse.

Test Plan:
- Frame 0x1C with parity 0 and stop 1, PS/2 half-period 1250 cycles, rd_ready=0 → rd_valid=1 two cycles after the stop edge, rd_data=0x1C, frame_err never high. Then rd_ready=1 for one cycle → rd_valid=0, rd_data=0x00.
- Back-to-back frames 0xFF (parity 1), 0x00 (parity 1), 0x5A (parity 1), then drain → bytes read in order 0xFF, 0x00, 0x5A, no errors.
- Frame 0x1C with parity 1 → one-cycle frame_err pulse, FIFO stays empty. Frame 0x1C with stop=0 → same response.
- Nine good frames 0x01..0x09 with rd_ready=0 → count 8, overflow=1, drain yields 0x01..0x08. Pulse clr_overflow → overflow=0. Separately: a push coinciding with a pop while full → no overflow.
- Start bit plus 4 data bits, then ps2_clk held high → frame_err pulses exactly TIMEOUT_CYCLES cycles after the last falling edge. A following 0x5A frame is received correctly.
- Reset asserted for 1 cycle after the 6th bit of a frame, with 3 bytes queued → rd_valid=0, overflow=0. Next full frame 0x1C is received cleanly.

Source files
------------

// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: synchronises the device clock/data pair, deserialises
// 11-bit frames and queues good bytes in a FIFO drained by a valid/ready reader.
module ps2_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [15:0] TCNT_ABORT = 16'(TIMEOUT_CYCLES - 2);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t      state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [3:0]  bitcnt;
  logic [9:0]  shreg;
  logic [15:0] tcnt;
  logic        frame_ok, push, pop, full, wr_en;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // shreg[7:0] = data LSB first, shreg[8] = parity, shreg[9] = stop
  assign frame_ok = (^shreg[7:0] ^ shreg[8]) & shreg[9];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt    <= 4'd0;
      shreg     <= 10'd0;
      tcnt      <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= 16'd0;
          if (fall && !dat_s2) begin
            state  <= RECV;
            bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            shreg[bitcnt - 4'd1] <= dat_s2;
            bitcnt               <= bitcnt + 4'd1;
            tcnt                 <= 16'd0;
            if (bitcnt == 4'd10) state <= CHECK;
          end else if (tcnt == TCNT_ABORT) begin
            frame_err <= 1'b1;
            bitcnt    <= 4'd0;
            tcnt      <= 16'd0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        CHECK: begin
          frame_err <= ~frame_ok;
          bitcnt    <= 4'd0;
          tcnt      <= 16'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push     = (state == CHECK) & frame_ok;
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (count == COUNT_FULL);
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign wr_en    = push & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= shreg[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: queue-based reference model compared every
// cycle, plus directed frames with hand-computed literal expectations.
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int TOUT  = 3000;
  localparam int HALF  = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       rd_valid, frame_err, overflow;
  logic [7:0] rd_data;

  ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_err(frame_err), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Reference model: byte queue, sticky overflow, error pulse, plus the
  // cycle-indexed events the stimulus predicts from each frame it sends.
  logic [7:0] mq[$];
  bit         m_ov = 1'b0;
  bit         m_err = 1'b0;
  bit         sched_err[int];
  logic [7:0] sched_push[int];
  bit         m_pop, m_push, m_full;
  logic [7:0] m_pb;

  int  err_pulses = 0;
  int  rise_cyc = 0;
  bit  prev_valid = 1'b0;
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      mq.delete();
      m_ov    = 1'b0;
      m_err   = 1'b0;
      started = 1'b1;
    end else begin
      m_pop  = (mq.size() != 0) && rd_ready;
      m_push = sched_push.exists(cyc);
      m_pb   = m_push ? sched_push[cyc] : 8'h00;
      m_full = (mq.size() == DEPTH);
      m_err  = sched_err.exists(cyc);
      if (m_pop) void'(mq.pop_front());
      if (m_push && m_full && !m_pop) m_ov = 1'b1;
      else begin
        if (m_push) mq.push_back(m_pb);
        if (clr_overflow) m_ov = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (started) begin
      check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("rd_data", 32'(rd_data), 32'((mq.size() != 0) ? mq[0] : 8'h00));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("overflow", 32'(overflow), 32'(m_ov));
    end
    if (frame_err) err_pulses++;
    if (rd_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rd_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Drives nbits of the frame {stop, parity, data, start}, LSB first.
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int half,
                      input int nbits, input bit pop_at_push, output int c_last);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    c_last = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      tick(half);
      ps2_clk = 1'b0;
      c_last = cyc;
      if (i == 10) begin
        // 2-cycle synchroniser + edge cycle + CHECK cycle before the outputs move
        if (((^d) ^ par) && stp) sched_push[cyc + 4] = d;
        else                     sched_err[cyc + 4] = 1'b1;
      end
      if (i == 10 && pop_at_push) begin
        tick(3);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(half - 4);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic good(input logic [7:0] d);
    int cc;
    send(d, ~^d, 1'b1, HALF, 11, 1'b0, cc);
  endtask

  task automatic drain();
    got.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clock);
      if (!rd_valid) break;
      got.push_back(rd_data);
      tick(1);
    end
    rd_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_got(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  int c, ecyc, e0;
  bit found;
  logic [7:0] exp_q[$];
  logic [7:0] b;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(5);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data", 32'(rd_data), 32'h00);
    check("reset_ovf", 32'(overflow), 32'd0);

    // slow frame 0x1C, correct parity 0
    send(8'h1C, 1'b0, 1'b1, 1250, 11, 1'b0, c);
    tick(5);
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_data", 32'(rd_data), 32'h1C);
    check("t1_latency", 32'(rise_cyc - c), 32'd4);
    check("t1_no_err", 32'(err_pulses), 32'd0);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    @(negedge clock);
    check("t1_pop_valid", 32'(rd_valid), 32'd0);
    check("t1_pop_data", 32'(rd_data), 32'h00);
    tick(1);

    send(8'hFF, 1'b1, 1'b1, HALF, 11, 1'b0, c);
    send(8'h00, 1'b1, 1'b1, HALF, 11, 1'b0, c);
    send(8'h5A, 1'b1, 1'b1, HALF, 11, 1'b0, c);
    tick(6);
    drain();
    exp_q = '{8'hFF, 8'h00, 8'h5A};
    check_got("t2_order", exp_q);
    check("t2_no_err", 32'(err_pulses), 32'd0);

    e0 = err_pulses;
    send(8'h1C, 1'b1, 1'b1, HALF, 11, 1'b0, c);
    tick(6);
    check("t3_parity_err", 32'(err_pulses - e0), 32'd1);
    check("t3_parity_empty", 32'(rd_valid), 32'd0);
    send(8'h1C, 1'b0, 1'b0, HALF, 11, 1'b0, c);
    tick(6);
    check("t3_stop_err", 32'(err_pulses - e0), 32'd2);
    check("t3_stop_empty", 32'(rd_valid), 32'd0);

    e0 = err_pulses;
    for (int k = 1; k <= 9; k++) good(8'(k));
    tick(6);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_no_err", 32'(err_pulses - e0), 32'd0);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_got("t4_drain", exp_q);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    @(negedge clock);
    check("t4_ovf_clear", 32'(overflow), 32'd0);
    tick(1);

    for (int k = 0; k < 8; k++) good(8'h10 + 8'(k));
    b = 8'h18;
    send(b, ~^b, 1'b1, HALF, 11, 1'b1, c);
    tick(6);
    check("t4_pushpop_ovf", 32'(overflow), 32'd0);
    drain();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    check_got("t4_pushpop", exp_q);

    // start + d0..d3 of 0x5A, then the device stalls
    e0 = err_pulses;
    send(8'h5A, 1'b1, 1'b1, HALF, 5, 1'b0, c);
    sched_err[c + 2 + TOUT] = 1'b1;
    found = 1'b0;
    ecyc = 0;
    for (int i = 0; i < TOUT + 200; i++) begin
      @(negedge clock);
      if (frame_err) begin
        found = 1'b1;
        ecyc = cyc;
        break;
      end
    end
    check("t5_timeout_seen", 32'(found), 32'd1);
    check("t5_timeout_delay", 32'(ecyc - c), 32'(TOUT + 2));
    tick(5);
    check("t5_one_pulse", 32'(err_pulses - e0), 32'd1);
    good(8'h5A);
    tick(6);
    drain();
    exp_q = '{8'h5A};
    check_got("t5_after", exp_q);

    good(8'h21);
    good(8'h22);
    good(8'h23);
    tick(6);
    check("t6_queued", 32'(rd_valid), 32'd1);
    send(8'h77, 1'b1, 1'b1, HALF, 6, 1'b0, c);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    check("t6_reset_valid", 32'(rd_valid), 32'd0);
    check("t6_reset_data", 32'(rd_data), 32'h00);
    check("t6_reset_ovf", 32'(overflow), 32'd0);
    tick(5);
    e0 = err_pulses;
    good(8'h1C);
    tick(6);
    check("t6_no_err", 32'(err_pulses - e0), 32'd0);
    drain();
    exp_q = '{8'h1C};
    check_got("t6_after", exp_q);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
